// File: rtl/hex_controller.sv
// hex_controller: memory-mapped eight-digit seven-segment display responder.
// Holds the DIGITS and MASK registers and answers reads combinationally.
// A prescaled scan engine time-multiplexes the digits onto one shared
// active-low segment bus.
module hex_controller #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [6:0]  hex_led_o,
    output logic [7:0]  hex_sel_o
);

    localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    localparam logic [1:0] W_DIGITS = 2'd0;
    localparam logic [1:0] W_MASK   = 2'd1;
    localparam logic [1:0] W_RST    = 2'd2;

    localparam logic [6:0] LED_BLANK = 7'h7F;
    localparam logic [7:0] SEL_OFF   = 8'hFF;

    logic [31:0]   digits_q, digits_d;
    logic [7:0]    mask_q,   mask_d;
    logic [PW-1:0] pre_q,    pre_d;
    logic [2:0]    idx_q,    idx_d;
    logic [6:0]    led_q,    led_d;
    logic [7:0]    sel_q,    sel_d;

    logic [1:0] word;
    logic       soft_rst;
    logic [3:0] cur_nib;
    logic       unused_addr;

    assign word        = addr_i[3:2];
    assign soft_rst    = we_i && (word == W_RST);
    assign cur_nib     = digits_q[{idx_q, 2'b00} +: 4];
    // Byte lanes inside a word are not decoded.
    assign unused_addr = ^addr_i[1:0];

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex value.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Read mux: same-cycle data for the addressed word.
    always_comb begin
        rdata_o = 32'h0;
        case (word)
            W_DIGITS: rdata_o = digits_q;
            W_MASK:   rdata_o = {24'h0, mask_q};
            default:  rdata_o = 32'h0;
        endcase
    end

    // Next state: scan advance, output stage from the current slot, register writes.
    always_comb begin
        pre_d    = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        idx_d    = (pre_q == PRE_MAX) ? idx_q + 3'd1 : idx_q;
        digits_d = digits_q;
        mask_d   = mask_q;

        // Outputs are built from pre-edge state so segments always match the anode.
        if (mask_q[idx_q]) begin
            sel_d = ~(8'd1 << idx_q);
            led_d = seg_decode(cur_nib);
        end else begin
            sel_d = SEL_OFF;
            led_d = LED_BLANK;
        end

        if (we_i) begin
            case (word)
                W_DIGITS: digits_d = wdata_i;
                W_MASK:   mask_d   = wdata_i[7:0];
                default:  ;
            endcase
        end

        // A write to the RST word behaves exactly like rst_i.
        if (soft_rst) begin
            digits_d = 32'h0;
            mask_d   = 8'hFF;
            pre_d    = '0;
            idx_d    = 3'd0;
            sel_d    = SEL_OFF;
            led_d    = LED_BLANK;
        end
    end

    // State registers; rst_i overrides any concurrent write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digits_q <= 32'h0;
            mask_q   <= 8'hFF;
            pre_q    <= '0;
            idx_q    <= 3'd0;
            led_q    <= LED_BLANK;
            sel_q    <= SEL_OFF;
        end else begin
            digits_q <= digits_d;
            mask_q   <= mask_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            led_q    <= led_d;
            sel_q    <= sel_d;
        end
    end

    assign hex_led_o = led_q;
    assign hex_sel_o = sel_q;

endmodule

// File: tb/tb_hex_controller.sv
// tb_hex_controller: directed plus randomized stimulus against a behavioural
// model that derives the active digit from elapsed cycles since reset.
module tb_hex_controller;

    localparam int DIV = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        we_i = 1'b0;
    logic [3:0]  addr_i = 4'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic [6:0]  hex_led_o;
    logic [7:0]  hex_sel_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [31:0] m_digits;
    logic [7:0]  m_mask;
    int          m_t;
    logic [6:0]  exp_led;
    logic [7:0]  exp_sel;

    logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_controller #(.SCAN_DIV(DIV)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .hex_led_o (hex_led_o),
        .hex_sel_o (hex_sel_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        case (a / 4)
            0:       return m_digits;
            1:       return {24'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic tick(input logic rst, input logic we, input logic [3:0] a, input logic [31:0] d);
        int k;
        rst_i = rst; we_i = we; addr_i = a; wdata_i = d;
        if (rst || (we && (a / 4) == 2)) begin
            m_digits = 32'h0;
            m_mask   = 8'hFF;
            m_t      = 0;
            exp_led  = 7'h7F;
            exp_sel  = 8'hFF;
        end else begin
            k = (m_t / DIV) % 8;
            if (m_mask[k]) begin
                exp_sel = 8'hFF ^ (8'd1 << k);
                exp_led = SEG[m_digits[4*k +: 4]];
            end else begin
                exp_sel = 8'hFF;
                exp_led = 7'h7F;
            end
            m_t++;
            if (we) begin
                if ((a / 4) == 0) m_digits = d;
                else if ((a / 4) == 1) m_mask = d[7:0];
            end
        end
        @(posedge clk_i);
        #1;
        chk("sel", {24'h0, hex_sel_o}, {24'h0, exp_sel});
        chk("led", {25'h0, hex_led_o}, {25'h0, exp_led});
        chk("rdata", rdata_o, exp_rd(a));
    endtask

    task automatic idle(input int n, input logic [3:0] a);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, a, 32'h0);
    endtask

    initial begin
        // Reset held two cycles, then read both registers
        tick(1'b1, 1'b0, 4'h0, 32'h0);
        tick(1'b1, 1'b0, 4'h4, 32'h0);
        chk("rst_mask", rdata_o, 32'h0000_00FF);
        idle(1, 4'h0);
        chk("rst_digits", rdata_o, 32'h0);

        // Full scan with a distinct value per digit, past one wrap
        tick(1'b0, 1'b1, 4'h0, 32'h7654_3210);
        idle(40, 4'h0);

        // Decode sweep of the upper values
        tick(1'b0, 1'b1, 4'h0, 32'hFEDC_BA98);
        idle(32, 4'h0);

        // Mask: only digits 0 and 2 enabled
        tick(1'b0, 1'b1, 4'h4, 32'hFFFF_FF05);
        chk("mask_rd", rdata_o, 32'h0000_0005);
        idle(34, 4'h4);

        // RST register mid-frame at scan index 5
        tick(1'b1, 1'b0, 4'h0, 32'h0);
        tick(1'b0, 1'b1, 4'h0, 32'hA5A5_5A5A);
        idle(19, 4'h0);
        tick(1'b0, 1'b1, 4'h8, 32'h1234_5678);
        idle(1, 4'h8);
        chk("rst_rd8", rdata_o, 32'h0);
        idle(1, 4'hC);
        idle(1, 4'h4);
        idle(6, 4'h0);

        // rst_i beats a concurrent write
        tick(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF);
        chk("prio", rdata_o, 32'h0);
        idle(3, 4'h0);

        // Reserved word ignores writes
        tick(1'b0, 1'b1, 4'hC, 32'hDEAD_BEEF);
        idle(1, 4'h0);
        idle(1, 4'h4);

        // Low address bits alias word 0
        tick(1'b0, 1'b1, 4'h3, 32'hCAFE_F00D);
        chk("alias", rdata_o, 32'hCAFE_F00D);
        idle(10, 4'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, w;
            logic [3:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 63) == 0);
            w = ($urandom_range(0, 3) == 0);
            a = 4'($urandom_range(0, 15));
            if ((a / 4) == 2 && $urandom_range(0, 7) != 0) a = a ^ 4'h8;
            d = $urandom;
            tick(r, w, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
